dmem_controller: RTL and testbench
==================================

# dmem_controller

Sequencing and arbitration controller for the 1024 x 32 data memory of the single-cycle core. Shares one synchronous single-port RAM between the CPU load/store port (base + 16-bit offset addressing) and a debug/dump port (absolute addressing). It also owns a hardware clear sequencer that zeroes the whole array on command, which replaces any per-cycle bulk clear in the datapath. It sits between the execute stage / debug master and the RAM macro.

## Interface
- ADDR_W, 10, word-address width; depth = 2**ADDR_W
- DATA_W, 32, data width
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = store, 0 = load
- cpu_base  in  32  base register value; only [ADDR_W-1:0] used
- cpu_offset  in  16  instruction immediate; only [ADDR_W-1:0] used
- cpu_wdata  in  DATA_W  store data
- cpu_gnt  out  1  combinational grant; access accepted on edge where cpu_req & cpu_gnt
- cpu_rvalid  out  1  load data valid
- cpu_rdata  out  DATA_W  load data; 0 when cpu_rvalid low
- dbg_req, dbg_we  in  1  debug request / write enable
- dbg_addr  in  ADDR_W  absolute word address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt, dbg_rvalid  out  1  as CPU port
- dbg_rdata  out  DATA_W  as CPU port
- clr_start  in  1  start full-array clear (level sampled each cycle)
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after last clear write
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en & !mem_we

## Operation
- FSM states: RUN, CLEAR. Reset -> RUN.
- RUN, clr_start=1: enter CLEAR next edge; no grants issued that cycle (clr_start beats both requesters).
- RUN arbitration: single requester granted immediately. Both requesting: grant the port not granted last (round-robin pointer `last`, updated only on accepted access). After reset `last`=DBG, so CPU wins first tie.
- CPU address = (cpu_base[ADDR_W-1:0] + cpu_offset[ADDR_W-1:0]) mod 2**ADDR_W; carry discarded (1020 + 10 -> 6).
- Accepted access drives mem_en=1, mem_we=port we, mem_addr, mem_wdata in the same cycle (combinational from grant). No access: mem_en=0, mem_we=0, mem_addr/mem_wdata = 0.
- Accepted load: registered tag sets that port's rvalid next cycle; rdata = mem_rdata in that cycle.
- CLEAR: counter 0..2**ADDR_W-1, one write of 0 per cycle (mem_en=1, mem_we=1); cpu_gnt=dbg_gnt=0; clr_busy=1. After writing address 2**ADDR_W-1: go to RUN, clr_done=1 for the first RUN cycle. clr_start during CLEAR ignored.
- A load accepted the cycle before entering CLEAR still returns rvalid/rdata in the first CLEAR cycle.
- Reset mid-CLEAR aborts; array left partially cleared (RAM is not reset); no clr_done.

## Timing
- Reset values: cpu_gnt=dbg_gnt=0 during reset, rvalid=0, rdata=0, clr_busy=0, clr_done=0, mem_en=mem_we=0, counter=0, last=DBG.
- Grant: 0 cycles (combinational from req, state, last). Store commits at accepting edge.
- Load latency: 1 cycle, request edge N -> rvalid high during cycle N+1. Back-to-back loads sustain one per cycle.
- Store at edge N then load of same address at edge N+1 returns the stored value.
- Clear: exactly 2**ADDR_W cycles busy (1024 default), clr_done at cycle 1025 after entry.
- Throughput: one RAM access per cycle total; losing requester holds req and is granted next cycle.

## Test plan
- Reset, then CPU store base=3 offset=4 data=0xDEAD -> mem_addr=7 same cycle; next cycle CPU load same -> cpu_rvalid one cycle later, cpu_rdata=0xDEAD.
- Wrap: base=1020, offset=10 store 0x55; dbg load addr 6 -> dbg_rdata=0x55.
- Both ports request continuously for 6 cycles -> grants alternate CPU, DBG, CPU, DBG, CPU, DBG; no cycle with both grants.
- Debug load accepted, clr_start next cycle -> dbg_rvalid still delivered; clr_busy high 1024 cycles, no grants; clr_done pulse once; subsequent loads of addr 0, 7, 1023 return 0.
- Assert reset at clear cycle 500 -> clr_busy=0 next cycle, no clr_done; addr 10 reads 0, addr 600 keeps prior value 0x1234.
- Store then immediate load same address from opposite ports on consecutive cycles -> load returns new data; rdata=0 whenever rvalid=0.

Source files
------------

// File: rtl/dmem_controller_if.sv
// Bus bundle for dmem_controller: CPU and debug request ports, clear control and the RAM macro side.
// master = requesters plus RAM model, slave = the controller itself.
interface dmem_controller_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_base;
  logic [15:0]       cpu_offset;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_base, cpu_offset, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output clr_start, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  clr_busy, clr_done,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_base, cpu_offset, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  clr_start, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output clr_busy, clr_done,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_controller.sv
// Shares one synchronous single-port data RAM between the CPU load/store port and the debug port,
// with round-robin arbitration and a hardware sequencer that zeroes the whole array.
module dmem_controller #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             reset,
  dmem_controller_if.slave bus
);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  state_t            r_state;
  logic              r_last;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_cpuTag;
  logic              r_dbgTag;
  logic              r_clrDone;

  logic              w_run;
  logic              w_cpuGnt;
  logic              w_dbgGnt;
  logic [ADDR_W-1:0] w_cpuAddr;
  logic              w_memEn;
  logic              w_memWe;
  logic [ADDR_W-1:0] w_memAddr;
  logic [DATA_W-1:0] w_memWdata;
  logic              w_unused;

  // A pending clear request outranks both requesters for the whole cycle.
  assign w_run     = !reset && (r_state == RUN) && !bus.clr_start;
  assign w_cpuGnt  = w_run && bus.cpu_req && (!bus.dbg_req || (r_last == PORT_DBG));
  assign w_dbgGnt  = w_run && bus.dbg_req && (!bus.cpu_req || (r_last == PORT_CPU));
  assign w_cpuAddr = bus.cpu_base[ADDR_W-1:0] + bus.cpu_offset[ADDR_W-1:0];
  assign w_unused  = ^{bus.cpu_base[31:ADDR_W], bus.cpu_offset[15:ADDR_W]};

  always_comb begin
    w_memEn    = 1'b0;
    w_memWe    = 1'b0;
    w_memAddr  = '0;
    w_memWdata = '0;
    if (!reset && (r_state == CLEAR)) begin
      w_memEn   = 1'b1;
      w_memWe   = 1'b1;
      w_memAddr = r_cnt;
    end else if (w_cpuGnt) begin
      w_memEn    = 1'b1;
      w_memWe    = bus.cpu_we;
      w_memAddr  = w_cpuAddr;
      w_memWdata = bus.cpu_wdata;
    end else if (w_dbgGnt) begin
      w_memEn    = 1'b1;
      w_memWe    = bus.dbg_we;
      w_memAddr  = bus.dbg_addr;
      w_memWdata = bus.dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_last    <= PORT_DBG;
      r_cnt     <= '0;
      r_cpuTag  <= 1'b0;
      r_dbgTag  <= 1'b0;
      r_clrDone <= 1'b0;
    end else begin
      r_cpuTag  <= w_cpuGnt && !bus.cpu_we;
      r_dbgTag  <= w_dbgGnt && !bus.dbg_we;
      r_clrDone <= 1'b0;
      case (r_state)
        RUN: begin
          if (bus.clr_start) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
          end else if (w_cpuGnt) begin
            r_last <= PORT_CPU;
          end else if (w_dbgGnt) begin
            r_last <= PORT_DBG;
          end
        end
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {ADDR_W{1'b1}}) begin
            r_state   <= RUN;
            r_clrDone <= 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.cpu_gnt    = w_cpuGnt;
  assign bus.dbg_gnt    = w_dbgGnt;
  assign bus.cpu_rvalid = r_cpuTag;
  assign bus.dbg_rvalid = r_dbgTag;
  assign bus.cpu_rdata  = r_cpuTag ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = r_dbgTag ? bus.mem_rdata : '0;
  assign bus.clr_busy   = (r_state == CLEAR);
  assign bus.clr_done   = r_clrDone;
  assign bus.mem_en     = w_memEn;
  assign bus.mem_we     = w_memWe;
  assign bus.mem_addr   = w_memAddr;
  assign bus.mem_wdata  = w_memWdata;

endmodule

// File: tb/tb_dmem_controller.sv
// Testbench for dmem_controller: behavioural RAM plus a word-array reference model and
// a round-robin pointer model driven by directed and random traffic.
module tb_dmem_controller;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam bit CPU   = 1'b0;
  localparam bit DBG   = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] model [DEPTH];
  bit   mLast;

  dmem_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initVal(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Synchronous single-port RAM macro; contents are not affected by reset.
  logic [31:0] ram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = initVal(i);
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        else bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit cReq, input bit cWe, input logic [31:0] base,
                               input logic [15:0] off, input logic [31:0] cData,
                               input bit dReq, input bit dWe, input logic [9:0] dAddr,
                               input logic [31:0] dData, input bit clr);
    bus.cpu_req    = cReq;
    bus.cpu_we     = cWe;
    bus.cpu_base   = base;
    bus.cpu_offset = off;
    bus.cpu_wdata  = cData;
    bus.dbg_req    = dReq;
    bus.dbg_we     = dWe;
    bus.dbg_addr   = dAddr;
    bus.dbg_wdata  = dData;
    bus.clr_start  = clr;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 32'd0, 16'd0, 32'd0, 0, 0, 10'd0, 32'd0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1, 1, 32'd5, 16'd5, 32'h1111, 1, 0, 10'd3, 32'h2222, 0);
    tick();
    tick();
    checks++; if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b00) begin failures++; $display("[TB] FAIL reset_gnt got=%b exp=00", {bus.cpu_gnt, bus.dbg_gnt}); end
    checks++; if ({bus.cpu_rvalid, bus.dbg_rvalid, bus.clr_busy, bus.clr_done} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", {bus.cpu_rvalid, bus.dbg_rvalid, bus.clr_busy, bus.clr_done}); end
    checks++; if ({bus.cpu_rdata, bus.dbg_rdata} !== 64'd0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", {bus.cpu_rdata, bus.dbg_rdata}); end
    checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== 12'd0) begin failures++; $display("[TB] FAIL reset_mem got=%h exp=0", {bus.mem_en, bus.mem_we, bus.mem_addr}); end
    applyIdle();
    reset = 1'b0;
    mLast = DBG;
  endtask

  task automatic test_basic();
    tick();
    applyStimulus(1, 1, 32'd3, 16'd4, 32'hDEAD, 0, 0, 10'd0, 32'd0, 0);
    checks++; if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b10) begin failures++; $display("[TB] FAIL basic_store_gnt got=%b exp=10", {bus.cpu_gnt, bus.dbg_gnt}); end
    checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b11, 10'd7}) begin failures++; $display("[TB] FAIL basic_store_addr got=%0d exp=7 en/we=%b", bus.mem_addr, {bus.mem_en, bus.mem_we}); end
    checks++; if (bus.mem_wdata !== 32'hDEAD) begin failures++; $display("[TB] FAIL basic_store_data got=%h exp=dead", bus.mem_wdata); end
    model[7] = 32'hDEAD; mLast = CPU;
    tick();
    checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'd0) begin failures++; $display("[TB] FAIL basic_store_norvalid got=%b/%h exp=0/0", bus.cpu_rvalid, bus.cpu_rdata); end
    applyStimulus(1, 0, 32'd3, 16'd4, 32'd0, 0, 0, 10'd0, 32'd0, 0);
    checks++; if ({bus.cpu_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {3'b110, 10'd7}) begin failures++; $display("[TB] FAIL basic_load_issue got=%b addr=%0d exp gnt/en=1 we=0 addr=7", {bus.cpu_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr); end
    tick();
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== model[7]) begin failures++; $display("[TB] FAIL basic_load_data got=%b/%h exp=1/%h", bus.cpu_rvalid, bus.cpu_rdata, model[7]); end
    applyIdle();
  endtask

  task automatic test_wrap();
    tick();
    applyStimulus(1, 1, 32'd1020, 16'd10, 32'h55, 0, 0, 10'd0, 32'd0, 0);
    checks++; if (bus.cpu_gnt !== 1'b1 || bus.mem_addr !== 10'd6) begin failures++; $display("[TB] FAIL wrap_addr got=%0d gnt=%b exp=6 gnt=1", bus.mem_addr, bus.cpu_gnt); end
    model[6] = 32'h55; mLast = CPU;
    tick();
    applyStimulus(0, 0, 32'd0, 16'd0, 32'd0, 1, 0, 10'd6, 32'd0, 0);
    checks++; if (bus.dbg_gnt !== 1'b1 || bus.mem_addr !== 10'd6 || bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL wrap_dbg_issue got gnt=%b addr=%0d we=%b exp 1/6/0", bus.dbg_gnt, bus.mem_addr, bus.mem_we); end
    mLast = DBG;
    tick();
    checks++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== model[6] || bus.cpu_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL wrap_dbg_data got=%b/%h cpu_rvalid=%b exp=1/%h cpu_rvalid=0", bus.dbg_rvalid, bus.dbg_rdata, bus.cpu_rvalid, model[6]); end
    applyIdle();
  endtask

  task automatic test_round_robin();
    logic [9:0] ca;
    logic [9:0] da;
    logic [1:0] expG;
    for (int i = 0; i < 6; i++) begin
      tick();
      ca = 10'($urandom);
      da = 10'($urandom);
      applyStimulus(1, 0, 32'(ca), 16'd0, 32'd0, 1, 0, da, 32'd0, 0);
      expG = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++; if ({bus.cpu_gnt, bus.dbg_gnt} !== expG) begin failures++; $display("[TB] FAIL rr_cycle%0d got=%b exp=%b", i, {bus.cpu_gnt, bus.dbg_gnt}, expG); end
      mLast = (i % 2 == 0) ? CPU : DBG;
    end
    tick();
    applyIdle();
  endtask

  task automatic test_opposite_ports();
    logic [9:0]  a;
    logic [31:0] d;
    logic [31:0] base;
    a = 10'($urandom); d = $urandom; base = $urandom;
    tick();
    applyStimulus(0, 0, 32'd0, 16'd0, 32'd0, 1, 1, a, d, 0);
    checks++; if ({bus.dbg_gnt, bus.mem_we, bus.mem_addr} !== {2'b11, a}) begin failures++; $display("[TB] FAIL opp_dbg_store got gnt/we=%b addr=%0d exp 11/%0d", {bus.dbg_gnt, bus.mem_we}, bus.mem_addr, a); end
    model[a] = d; mLast = DBG;
    tick();
    applyStimulus(1, 0, base, 16'((32'(a) - base) % 1024), 32'd0, 0, 0, 10'd0, 32'd0, 0);
    checks++; if (bus.cpu_gnt !== 1'b1 || bus.mem_addr !== a) begin failures++; $display("[TB] FAIL opp_cpu_load_addr got=%0d exp=%0d", bus.mem_addr, a); end
    mLast = CPU;
    tick();
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== model[a] || bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 32'd0) begin failures++; $display("[TB] FAIL opp_cpu_load_data got=%b/%h dbg=%b/%h exp=1/%h dbg=0/0", bus.cpu_rvalid, bus.cpu_rdata, bus.dbg_rvalid, bus.dbg_rdata, model[a]); end
    a = 10'($urandom); d = $urandom; base = $urandom;
    applyStimulus(1, 1, base, 16'((32'(a) - base) % 1024), d, 0, 0, 10'd0, 32'd0, 0);
    checks++; if ({bus.cpu_gnt, bus.mem_we, bus.mem_addr} !== {2'b11, a} || bus.mem_wdata !== d) begin failures++; $display("[TB] FAIL opp_cpu_store got addr=%0d data=%h exp %0d/%h", bus.mem_addr, bus.mem_wdata, a, d); end
    model[a] = d; mLast = CPU;
    tick();
    applyStimulus(0, 0, 32'd0, 16'd0, 32'd0, 1, 0, a, 32'd0, 0);
    mLast = DBG;
    tick();
    checks++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== model[a] || bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'd0) begin failures++; $display("[TB] FAIL opp_dbg_load_data got=%b/%h cpu=%b/%h exp=1/%h cpu=0/0", bus.dbg_rvalid, bus.dbg_rdata, bus.cpu_rvalid, bus.cpu_rdata, model[a]); end
    applyIdle();
  endtask

  task automatic test_random();
    bit expCv = 0, expDv = 0, expC, expD, cReq, cWe, dReq, dWe;
    logic [31:0] expCd = 0, expDd = 0, base, cData, dData;
    logic [15:0] off;
    logic [9:0]  dAddr, a;
    for (int n = 0; n < 300; n++) begin
      tick();
      checks++; if (bus.cpu_rvalid !== expCv || bus.cpu_rdata !== (expCv ? expCd : 32'd0)) begin failures++; $display("[TB] FAIL rand_cpu_rdata n=%0d got=%b/%h exp=%b/%h", n, bus.cpu_rvalid, bus.cpu_rdata, expCv, expCv ? expCd : 32'd0); end
      checks++; if (bus.dbg_rvalid !== expDv || bus.dbg_rdata !== (expDv ? expDd : 32'd0)) begin failures++; $display("[TB] FAIL rand_dbg_rdata n=%0d got=%b/%h exp=%b/%h", n, bus.dbg_rvalid, bus.dbg_rdata, expDv, expDv ? expDd : 32'd0); end
      cReq = ($urandom_range(0, 9) < 6); cWe = 1'($urandom); base = $urandom; off = 16'($urandom); cData = $urandom;
      dReq = ($urandom_range(0, 9) < 6); dWe = 1'($urandom); dAddr = 10'($urandom); dData = $urandom;
      applyStimulus(cReq, cWe, base, off, cData, dReq, dWe, dAddr, dData, 0);
      expC = cReq && (!dReq || mLast == DBG);
      expD = dReq && (!cReq || mLast == CPU);
      checks++; if ({bus.cpu_gnt, bus.dbg_gnt} !== {expC, expD}) begin failures++; $display("[TB] FAIL rand_gnt n=%0d got=%b exp=%b", n, {bus.cpu_gnt, bus.dbg_gnt}, {expC, expD}); end
      expCv = 0; expDv = 0;
      if (expC) begin
        a = 10'((base + 32'(off)) % 1024);
        checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, cWe, a} || (cWe && bus.mem_wdata !== cData)) begin failures++; $display("[TB] FAIL rand_cpu_mem n=%0d got en/we=%b addr=%0d data=%h exp 1%b/%0d/%h", n, {bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata, cWe, a, cData); end
        if (cWe) model[a] = cData; else begin expCv = 1; expCd = model[a]; end
        mLast = CPU;
      end else if (expD) begin
        checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, dWe, dAddr} || (dWe && bus.mem_wdata !== dData)) begin failures++; $display("[TB] FAIL rand_dbg_mem n=%0d got en/we=%b addr=%0d data=%h exp 1%b/%0d/%h", n, {bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata, dWe, dAddr, dData); end
        if (dWe) model[dAddr] = dData; else begin expDv = 1; expDd = model[dAddr]; end
        mLast = DBG;
      end else begin
        checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== 12'd0 || bus.mem_wdata !== 32'd0) begin failures++; $display("[TB] FAIL rand_idle_mem n=%0d got=%h/%h exp=0/0", n, {bus.mem_en, bus.mem_we, bus.mem_addr}, bus.mem_wdata); end
      end
    end
    tick();
    checks++; if (bus.cpu_rvalid !== expCv || bus.cpu_rdata !== (expCv ? expCd : 32'd0) || bus.dbg_rvalid !== expDv || bus.dbg_rdata !== (expDv ? expDd : 32'd0)) begin failures++; $display("[TB] FAIL rand_drain got=%b%b exp=%b%b", bus.cpu_rvalid, bus.dbg_rvalid, expCv, expDv); end
    applyIdle();
  endtask

  task automatic test_clear();
    logic [31:0] exp7;
    logic [9:0]  probe [3];
    int busyCnt = 0, doneCnt = 0, grantsBusy = 0, addrErr = 0, doneAt = -1, cyc = 0;
    tick();
    applyStimulus(0, 0, 32'd0, 16'd0, 32'd0, 1, 0, 10'd7, 32'd0, 0);
    checks++; if (bus.dbg_gnt !== 1'b1) begin failures++; $display("[TB] FAIL clr_pre_load_gnt got=%b exp=1", bus.dbg_gnt); end
    exp7 = model[7]; mLast = DBG;
    tick();
    applyStimulus(1, 0, 32'd0, 16'd0, 32'd0, 1, 0, 10'd7, 32'd0, 1);
    checks++; if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b00) begin failures++; $display("[TB] FAIL clr_start_blocks_gnt got=%b exp=00", {bus.cpu_gnt, bus.dbg_gnt}); end
    checks++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== exp7) begin failures++; $display("[TB] FAIL clr_pre_load_data got=%b/%h exp=1/%h", bus.dbg_rvalid, bus.dbg_rdata, exp7); end
    while (doneCnt == 0 && cyc < 1100) begin
      tick();
      cyc++;
      if (bus.clr_done) begin doneCnt++; doneAt = cyc; end
      if (bus.clr_busy) begin
        applyStimulus(1, 1, 32'd0, 16'd0, 32'hFFFF, 1, 1, 10'd3, 32'hFFFF, busyCnt < 5);
        if (bus.cpu_gnt || bus.dbg_gnt) grantsBusy++;
        if (!(bus.mem_en && bus.mem_we && bus.mem_addr == busyCnt[9:0] && bus.mem_wdata == 32'd0)) addrErr++;
        busyCnt++;
      end else begin
        applyIdle();
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.clr_done) doneCnt++;
      if (bus.clr_busy) busyCnt++;
    end
    checks++; if (busyCnt !== 1024) begin failures++; $display("[TB] FAIL clr_busy_cycles got=%0d exp=1024", busyCnt); end
    checks++; if (grantsBusy !== 0) begin failures++; $display("[TB] FAIL clr_grants_while_busy got=%0d exp=0", grantsBusy); end
    checks++; if (addrErr !== 0) begin failures++; $display("[TB] FAIL clr_write_sequence got=%0d bad cycles exp=0", addrErr); end
    checks++; if (doneCnt !== 1 || doneAt !== 1025) begin failures++; $display("[TB] FAIL clr_done_pulse got count=%0d at=%0d exp 1 at 1025", doneCnt, doneAt); end
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    probe[0] = 10'd0; probe[1] = 10'd7; probe[2] = 10'd1023;
    for (int k = 0; k < 3; k++) begin
      tick();
      applyStimulus(1, 0, 32'(probe[k]), 16'd0, 32'd0, 0, 0, 10'd0, 32'd0, 0);
      mLast = CPU;
      tick();
      checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== model[probe[k]]) begin failures++; $display("[TB] FAIL clr_readback addr=%0d got=%b/%h exp=1/%h", probe[k], bus.cpu_rvalid, bus.cpu_rdata, model[probe[k]]); end
      applyIdle();
    end
  endtask

  task automatic test_reset_abort();
    int busyCnt = 0, cyc = 0, lateFlags = 0;
    tick();
    applyStimulus(1, 1, 32'd600, 16'd0, 32'h1234, 0, 0, 10'd0, 32'd0, 0);
    model[600] = 32'h1234; mLast = CPU;
    tick();
    applyStimulus(0, 0, 32'd0, 16'd0, 32'd0, 1, 1, 10'd10, 32'hBEEF, 0);
    model[10] = 32'hBEEF; mLast = DBG;
    tick();
    applyStimulus(0, 0, 32'd0, 16'd0, 32'd0, 0, 0, 10'd0, 32'd0, 1);
    while (busyCnt < 500 && cyc < 1100) begin
      tick();
      cyc++;
      if (bus.clr_busy) busyCnt++;
      applyIdle();
    end
    checks++; if (busyCnt !== 500) begin failures++; $display("[TB] FAIL abort_reach_cycle500 got=%0d exp=500", busyCnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy_after_reset got busy=%b done=%b exp 0/0", bus.clr_busy, bus.clr_done); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.clr_busy || bus.clr_done) lateFlags++;
    end
    checks++; if (lateFlags !== 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d flagged cycles exp=0", lateFlags); end
    for (int i = 0; i < 499; i++) model[i] = 32'd0;
    mLast = DBG;
    applyStimulus(1, 0, 32'd10, 16'd0, 32'd0, 1, 0, 10'd600, 32'd0, 0);
    checks++; if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b10) begin failures++; $display("[TB] FAIL abort_first_tie got=%b exp=10", {bus.cpu_gnt, bus.dbg_gnt}); end
    mLast = CPU;
    tick();
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== model[10]) begin failures++; $display("[TB] FAIL abort_addr10 got=%b/%h exp=1/%h", bus.cpu_rvalid, bus.cpu_rdata, model[10]); end
    checks++; if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b01) begin failures++; $display("[TB] FAIL abort_second_tie got=%b exp=01", {bus.cpu_gnt, bus.dbg_gnt}); end
    mLast = DBG;
    tick();
    checks++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== model[600]) begin failures++; $display("[TB] FAIL abort_addr600 got=%b/%h exp=1/%h", bus.dbg_rvalid, bus.dbg_rdata, model[600]); end
    applyIdle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = initVal(i);
    $display("[TB] dmem_controller bench start");
    test_reset();
    test_basic();
    test_wrap();
    test_round_robin();
    test_opposite_ports();
    test_random();
    test_clear();
    test_reset_abort();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
